// File: rtl/chunked_adder_nbit_if.sv
// Operand/result bundle for chunked_adder_nbit: the source drives start and operands,
// the adder returns busy, done and the registered result.
`timescale 1ns/1ps
interface chunked_adder_nbit_if #(
  parameter int NUM_BITS = 8
);
  logic                start;
  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] b;
  logic                carry_in;
  logic                busy;
  logic                done;
  logic [NUM_BITS-1:0] sum;
  logic                overflow;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, overflow
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, overflow
  );
endinterface

// File: rtl/chunked_adder_nbit.sv
// Multi-cycle ripple adder: adds CHUNK_BITS of a + b + carry_in per clock and
// publishes the wrapped sum and overflow flag with a one-cycle done pulse.
`timescale 1ns/1ps
module chunked_adder_nbit #(
  parameter int NUM_BITS   = 8,
  parameter int CHUNK_BITS = 2,
  parameter int SIGNED_OVF = 0
) (
  input logic                 clk,
  input logic                 n_rst,
  chunked_adder_nbit_if.slave bus
);
  localparam int NUM_CHUNKS = NUM_BITS / CHUNK_BITS;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [CHUNK_BITS:0] add_chunk(
    input logic [CHUNK_BITS-1:0] x,
    input logic [CHUNK_BITS-1:0] y,
    input logic                  c
  );
    return {1'b0, x} + {1'b0, y} + {{CHUNK_BITS{1'b0}}, c};
  endfunction

  state_t              state_r;
  logic [NUM_BITS-1:0] op_a_r;
  logic [NUM_BITS-1:0] op_b_r;
  logic                carry_r;
  logic [IDX_W-1:0]    idx_r;
  logic [NUM_BITS-1:0] work_r;
  logic [NUM_BITS-1:0] sum_r;
  logic                overflow_r;
  logic                busy_r;
  logic                done_r;

  int                  base_s;
  logic [CHUNK_BITS:0] chunk_s;
  logic [NUM_BITS-1:0] work_next_s;
  logic                ovf_s;
  logic                last_s;

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.sum      = sum_r;
  assign bus.overflow = overflow_r;

  // Current chunk addition and the overflow the result would carry if this is the last chunk
  always_comb begin
    base_s      = 32'(idx_r) * CHUNK_BITS;
    chunk_s     = add_chunk(op_a_r[base_s +: CHUNK_BITS], op_b_r[base_s +: CHUNK_BITS], carry_r);
    work_next_s = work_r;
    work_next_s[base_s +: CHUNK_BITS] = chunk_s[CHUNK_BITS-1:0];
    last_s      = (idx_r == LAST_IDX);
    if (SIGNED_OVF != 0) begin
      ovf_s = (op_a_r[NUM_BITS-1] == op_b_r[NUM_BITS-1]) &&
              (work_next_s[NUM_BITS-1] != op_a_r[NUM_BITS-1]);
    end else begin
      ovf_s = chunk_s[CHUNK_BITS];
    end
  end

  // Handshake FSM with operand capture, chunk accumulation and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r    <= IDLE;
      op_a_r     <= '0;
      op_b_r     <= '0;
      carry_r    <= 1'b0;
      idx_r      <= '0;
      work_r     <= '0;
      sum_r      <= '0;
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            op_a_r  <= bus.a;
            op_b_r  <= bus.b;
            carry_r <= bus.carry_in;
            idx_r   <= '0;
            work_r  <= '0;
            busy_r  <= 1'b1;
            state_r <= ADD;
          end
        end
        ADD: begin
          work_r  <= work_next_s;
          carry_r <= chunk_s[CHUNK_BITS];
          if (last_s) begin
            sum_r      <= work_next_s;
            overflow_r <= ovf_s;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            state_r    <= DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          done_r <= 1'b0;
          // A start seen while done is high begins the next operation immediately
          if (bus.start) begin
            op_a_r  <= bus.a;
            op_b_r  <= bus.b;
            carry_r <= bus.carry_in;
            idx_r   <= '0;
            work_r  <= '0;
            busy_r  <= 1'b1;
            state_r <= ADD;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_chunked_adder_nbit.sv
// Self-checking bench for chunked_adder_nbit: 8-bit unsigned/signed-overflow pair plus
// two 4-bit variants, checked against a plain arithmetic reference.
`timescale 1ns/1ps
module tb_chunked_adder_nbit;
  logic clk;
  logic n_rst;
  int   n_checks;
  int   n_pass;

  chunked_adder_nbit_if #(.NUM_BITS(8)) i8u ();
  chunked_adder_nbit_if #(.NUM_BITS(8)) i8s ();
  chunked_adder_nbit_if #(.NUM_BITS(4)) i4a ();
  chunked_adder_nbit_if #(.NUM_BITS(4)) i4b ();

  chunked_adder_nbit #(.NUM_BITS(8), .CHUNK_BITS(2), .SIGNED_OVF(0)) u8u (.clk(clk), .n_rst(n_rst), .bus(i8u));
  chunked_adder_nbit #(.NUM_BITS(8), .CHUNK_BITS(2), .SIGNED_OVF(1)) u8s (.clk(clk), .n_rst(n_rst), .bus(i8s));
  chunked_adder_nbit #(.NUM_BITS(4), .CHUNK_BITS(1), .SIGNED_OVF(0)) u4a (.clk(clk), .n_rst(n_rst), .bus(i4a));
  chunked_adder_nbit #(.NUM_BITS(4), .CHUNK_BITS(4), .SIGNED_OVF(1)) u4b (.clk(clk), .n_rst(n_rst), .bus(i4b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: {signed_ovf, unsigned_ovf, sum} from a widened a + b + cin
  function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] full;
    full = 9'(a) + 9'(b) + 9'(cin);
    return {(a[7] == b[7]) && (full[7] != a[7]), full[8], full[7:0]};
  endfunction

  function automatic logic [5:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] full;
    full = 5'(a) + 5'(b) + 5'(cin);
    return {(a[3] == b[3]) && (full[3] != a[3]), full[4], full[3:0]};
  endfunction

  task automatic drive8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic c);
    i8u.start = s; i8u.a = a; i8u.b = b; i8u.carry_in = c;
    i8s.start = s; i8s.a = a; i8s.b = b; i8s.carry_in = c;
  endtask

  task automatic drive4(input logic s, input logic [3:0] a, input logic [3:0] b, input logic c);
    i4a.start = s; i4a.a = a; i4a.b = b; i4a.carry_in = c;
    i4b.start = s; i4b.a = a; i4b.b = b; i4b.carry_in = c;
  endtask

  // One 8-bit operation; poke >= 0 pulses start with junk operands at that busy cycle
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin, input int poke);
    logic [9:0] r;
    int dones, busy_cnt, lat;
    r = ref8(a, b, cin);
    drive8(1'b1, a, b, cin);
    @(posedge clk);
    @(negedge clk);
    dones = 0; busy_cnt = 0; lat = -1;
    for (int c = 0; c < 10; c++) begin
      drive8(c == poke, 8'($urandom), 8'($urandom), 1'($urandom));
      if (i8u.busy) busy_cnt++;
      if (i8u.done) begin
        dones++;
        if (lat < 0) begin
          lat = c;
          chk("sum8u", i8u.sum, r[7:0]);
          chk("ovf8u", i8u.overflow, r[8]);
          chk("done8s", i8s.done, 1'b1);
          chk("sum8s", i8s.sum, r[7:0]);
          chk("ovf8s", i8s.overflow, r[9]);
        end
      end
      @(negedge clk);
    end
    chk("done8_count", dones, 1);
    chk("busy8_cycles", busy_cnt, 4);
    chk("latency8", lat, 4);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [5:0] r;
    logic got_a, got_b;
    r = ref4(a, b, cin);
    drive4(1'b1, a, b, cin);
    @(posedge clk);
    @(negedge clk);
    got_a = 1'b0; got_b = 1'b0;
    for (int c = 0; c < 8 && !(got_a && got_b); c++) begin
      drive4(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
      if (i4a.done && !got_a) begin
        got_a = 1'b1;
        chk("sum4a", i4a.sum, r[3:0]);
        chk("ovf4a", i4a.overflow, r[4]);
        chk("latency4a", c, 4);
      end
      if (i4b.done && !got_b) begin
        got_b = 1'b1;
        chk("sum4b", i4b.sum, r[3:0]);
        chk("ovf4b", i4b.overflow, r[5]);
        chk("latency4b", c, 1);
      end
      @(negedge clk);
    end
    if (!got_a) chk("timeout4a", 0, 1);
    if (!got_b) chk("timeout4b", 0, 1);
  endtask

  initial begin
    logic [9:0] r1, r2;
    int lat1, lat2, dones;
    n_checks = 0;
    n_pass   = 0;
    n_rst    = 1'b0;
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    drive4(1'b0, 4'h0, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_busy", i8u.busy, 1'b0);
    chk("rst_done", i8u.done, 1'b0);
    chk("rst_sum", i8u.sum, 8'h00);
    chk("rst_ovf", i8u.overflow, 1'b0);
    n_rst = 1'b1;
    @(negedge clk);

    run8(8'h35, 8'h4A, 1'b1, -1);
    run8(8'hFF, 8'h01, 1'b0, -1);
    run8(8'h7F, 8'h7F, 1'b1, 1);
    run8(8'h80, 8'h80, 1'b0, 2);
    for (int i = 0; i < 40; i++) run8(8'($urandom), 8'($urandom), 1'($urandom), -1);

    // Back-to-back: start stays high through the done cycle
    r1 = ref8(8'hC3, 8'h5A, 1'b1);
    r2 = ref8(8'h19, 8'hE7, 1'b0);
    drive8(1'b1, 8'hC3, 8'h5A, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive8(1'b1, 8'h19, 8'hE7, 1'b0);
    lat1 = -1; lat2 = -1;
    for (int c = 0; c < 14; c++) begin
      if (i8u.done && lat1 < 0) begin
        lat1 = c;
        chk("b2b_sum1", i8u.sum, r1[7:0]);
        chk("b2b_ovf1", i8u.overflow, r1[8]);
      end else if (i8u.done && lat2 < 0) begin
        lat2 = c;
        chk("b2b_sum2", i8u.sum, r2[7:0]);
        chk("b2b_ovf2", i8u.overflow, r2[8]);
        chk("b2b_ovf2s", i8s.overflow, r2[9]);
      end
      if (lat1 >= 0 && c > lat1) drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      @(negedge clk);
    end
    chk("b2b_lat1", lat1, 4);
    chk("b2b_gap", lat2 - lat1, 5);

    // Reset in the middle of an operation, after a nonzero result is held
    run8(8'h35, 8'h4A, 1'b1, -1);
    drive8(1'b1, 8'h12, 8'h34, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    chk("midrst_busy", i8u.busy, 1'b0);
    chk("midrst_done", i8u.done, 1'b0);
    chk("midrst_sum", i8u.sum, 8'h00);
    chk("midrst_ovf", i8s.overflow, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (i8u.done) dones++;
    end
    chk("midrst_no_done", dones, 0);
    chk("midrst_sum_held", i8u.sum, 8'h00);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run4(4'(a), 4'(b), 1'(c));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
